// File: rtl/comma_aligner.sv
// Serial 8b10b comma aligner. It finds K28.5 in either disparity and keeps symbol
// alignment with a hunt/verify/locked FSM. It also deserialises aligned symbols.
// rst asserts asynchronously. Its release is expected to be synchronised to clk upstream.
module comma_aligner #(
    parameter int                SYM_W     = 10,
    parameter logic [SYM_W-1:0]  COMMA_NEG = SYM_W'(10'b0011111010),
    parameter logic [SYM_W-1:0]  COMMA_POS = SYM_W'(10'b1100000101),
    parameter int                LOCK_CNT  = 3,
    parameter int                LOSS_CNT  = 4,
    localparam int               PH_W      = $clog2(SYM_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             entrada,
    output logic             esk285,
    output logic             locked,
    output logic             lectura,
    output logic [SYM_W-1:0] dataOut,
    output logic             dataValid,
    output logic [PH_W-1:0]  phase
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SYM_W-2:0]   shift_q, shift_d;
    logic [3:0]         fill_q, fill_d;
    logic [3:0]         good_q, good_d;
    logic [3:0]         bad_q, bad_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               esk_q, esk_d;
    logic               lect_q, lect_d;
    logic [SYM_W-1:0]   data_q, data_d;
    logic               dv_q, dv_d;

    logic [SYM_W-1:0]   window_s;
    logic               hit_s;
    logic               boundary_s;
    logic               realign_s;
    logic               capture_s;
    logic [3:0]         good_inc_s;
    logic [3:0]         bad_inc_s;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v == 4'hF) begin
            return v;
        end else begin
            return v + 4'd1;
        end
    endfunction

    assign window_s   = {shift_q, entrada};
    // Compares are suppressed until the shift register holds only received bits.
    assign hit_s      = (fill_q == 4'd0) &&
                        ((window_s == COMMA_NEG) || (window_s == COMMA_POS));
    assign boundary_s = (phase_q == PH_W'(SYM_W-1));
    assign good_inc_s = sat_inc(good_q);
    assign bad_inc_s  = sat_inc(bad_q);

    // Next-state logic: alignment FSM, counters, phase and symbol capture
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        fill_d    = fill_q;
        good_d    = good_q;
        bad_d     = bad_q;
        phase_d   = phase_q;
        lect_d    = lect_q;
        data_d    = data_q;
        esk_d     = 1'b0;
        dv_d      = 1'b0;
        realign_s = 1'b0;
        capture_s = 1'b0;

        if (enb) begin
            shift_d = window_s[SYM_W-2:0];
            esk_d   = hit_s;
            if (fill_q != 4'd0) begin
                fill_d = fill_q - 4'd1;
            end else begin
                fill_d = fill_q;
            end
            if (boundary_s) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end

            case (state_q)
                ST_HUNT: begin
                    if (hit_s) begin
                        realign_s = 1'b1;
                        good_d    = 4'd1;
                        bad_d     = 4'd0;
                        state_d   = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_VERIFY: begin
                    if (hit_s && boundary_s) begin
                        good_d = good_inc_s;
                        if (good_inc_s >= 4'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else if (hit_s) begin
                        realign_s = 1'b1;
                        good_d    = 4'd1;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
                ST_LOCKED: begin
                    if (hit_s && boundary_s) begin
                        bad_d  = 4'd0;
                        lect_d = ~lect_q;
                    end else if (hit_s) begin
                        bad_d = bad_inc_s;
                        // Loss of lock does not realign; HUNT picks up the next comma.
                        if (bad_inc_s >= 4'(LOSS_CNT)) begin
                            state_d = ST_HUNT;
                            lect_d  = 1'b0;
                            good_d  = 4'd0;
                            bad_d   = 4'd0;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    good_d  = 4'd0;
                    bad_d   = 4'd0;
                    lect_d  = 1'b0;
                end
            endcase

            capture_s = realign_s || (boundary_s && (state_q != ST_HUNT));
            if (realign_s) begin
                phase_d = '0;
            end else begin
                phase_d = phase_d;
            end
            if (capture_s) begin
                data_d = window_s;
                dv_d   = 1'b1;
            end else begin
                data_d = data_q;
            end
        end else begin
            esk_d = 1'b0;
            dv_d  = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HUNT;
            shift_q <= '0;
            fill_q  <= 4'(SYM_W-1);
            good_q  <= 4'd0;
            bad_q   <= 4'd0;
            phase_q <= '0;
            esk_q   <= 1'b0;
            lect_q  <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            fill_q  <= fill_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            phase_q <= phase_d;
            esk_q   <= esk_d;
            lect_q  <= lect_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
        end
    end

    assign esk285    = esk_q;
    assign locked    = (state_q == ST_LOCKED);
    assign lectura   = lect_q;
    assign dataOut   = data_q;
    assign dataValid = dv_q;
    assign phase     = phase_q;

endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
- Parametrised successor to the single-pattern k28.5 detector.
- Watches a serial 8b10b bit stream for the comma symbol in both running-disparity forms (K28.5, RD-1 and RD+1).
- Acquires and keeps symbol alignment through a hunt/verify/locked state machine, then deserialises aligned symbols into parallel words.
- Sits between the serial receive path and the 8b10b decoder.

Parameters:
- SYM_W, 10, symbol width in bits; legal range 4..16.
- COMMA_NEG, 10'b0011111010, comma pattern for RD-1, SYM_W bits wide, first-received bit is the MSB.
- COMMA_POS, 10'b1100000101, comma pattern for RD+1, SYM_W bits wide.
- LOCK_CNT, 3, number of aligned commas needed to declare lock; legal range 1..15.
- LOSS_CNT, 4, number of misaligned commas that drops lock; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock, one serial bit per enabled cycle.
- rst  in  1  asynchronous, active-low reset; it takes effect immediately when asserted and releases synchronously to clk.
- enb  in  1  bit-enable; when low, all state is held and the pulse outputs are forced low.
- entrada  in  1  serial data bit.
- esk285  out  1  one-cycle pulse: a comma was seen in the window at any alignment.
- locked  out  1  high while in the LOCKED state.
- lectura  out  1  frame flag; toggles on each aligned comma while locked.
- dataOut  out  SYM_W  last aligned symbol, with the first-received bit as the MSB.
- dataValid  out  1  one-cycle pulse: dataOut was updated.
- phase  out  log2(SYM_W)  current bit position within the symbol.

Behaviour:
- Reset values: esk285=0, locked=0, lectura=0, dataOut=0, dataValid=0, phase=0.
  - Internally: state=HUNT, good count=0, bad count=0, fill counter=SYM_W-1.
- Shift register: SYM_W-1 bits, shifted on every enabled cycle. The comparison window is {shift[SYM_W-2:0], entrada}.
- Fill guard: the fill counter decrements on each enabled cycle. While it is nonzero, no comparison takes place, esk285 stays 0 and the state stays HUNT. This prevents matches against undefined bits.
- Comma match: the window equals COMMA_NEG or COMMA_POS. esk285 is registered and goes high on the clock edge that samples the last comma bit, so it is visible in the next cycle.
- Boundary: phase == SYM_W-1.
  - phase increments by 1 per enabled cycle and wraps from SYM_W-1 to 0.
  - Phase is forced to 0 on the cycle after any realign.
- States:
  - HUNT:
    - On a comma match: realign (next phase=0), set good count=1.
    - If LOCK_CNT==1, go directly to LOCKED; otherwise go to VERIFY.
  - VERIFY:
    - Comma on a boundary: good count +1. When good count reaches LOCK_CNT, go to LOCKED.
    - Comma off a boundary: realign, set good count=1, stay in VERIFY.
    - Non-comma symbols on a boundary are ignored.
  - LOCKED:
    - Comma on a boundary: clear the bad count and toggle lectura.
    - Comma off a boundary: bad count +1. When it reaches LOSS_CNT, go to HUNT, clear locked and lectura, and clear good/bad counts. No realign takes place on that cycle.
- Deserialisation:
  - In VERIFY or LOCKED, at every boundary (including the symbol that caused a realign), dataOut is loaded with the window and dataValid pulses for 1 cycle.
  - Latency is 1 clock after the last symbol bit is sampled.
  - No dataValid is produced in HUNT.
- Simultaneous events:
  - A comma that completes on a boundary in VERIFY is counted, not realigned.
  - When the lock transition and data capture occur on the same edge, both take effect. dataValid pulses and locked rises on the same edge.
- enb low: phase, counters, state, shift register and lectura hold; esk285=0 and dataValid=0. A comma is not split by gaps in enb.
- Mid-operation reset: all state clears immediately. After release, the full SYM_W-1 fill period applies again.
- Widths: counters are 4 bits and saturate; they do not wrap past 15.

Test Plan:
1. Reset held for 5 clocks, then 9 enabled bits of 1 followed by 0011111010 -> esk285 pulses exactly once, 1 clock after the 10th comma bit; no pulse occurs during fill.
2. Three repetitions of 0011111010 followed by D21.5 (1010101010), default parameters -> locked rises 1 clock after the 3rd comma; dataValid pulses with dataOut=0011111010 three times, then dataOut=1010101010.
3. Locked stream alternating COMMA_NEG and COMMA_POS (1100000101) -> both forms are accepted; lectura toggles on every comma; locked stays 1.
4. Once locked, insert 1 bit of slip, then commas at the shifted phase -> esk285 still pulses each time; locked falls after the 4th misaligned comma; after 3 further commas, lock is re-acquired at the new phase.
5. Once locked, drop enb for 7 random cycles mid-symbol -> phase and dataOut hold; esk285=0 and dataValid=0 while enb is low; the next symbol is still captured correctly.
6. Assert rst (drive low) asynchronously mid-symbol while locked -> locked, lectura, dataValid and phase go to 0 before the next clock edge; after release, the first esk285 can occur no earlier than the 10th enabled bit.
